// File: rtl/contatore_modulo_pkg.sv
// rtl/contatore_modulo_pkg.sv - shared constants and parameter checks for contatore_modulo
//
// Purpose : counting-mode constants and the elaboration-time parameter check
//           used by contatore_modulo.
// Contents: MODE_WRAP / MODE_SAT, PRESC_CW, params_ok().

package contatore_modulo_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Width of the prescaler count register (covers PRESC up to 65535).
   localparam int PRESC_CW  = 16;

   // Returns 1 when the parameter set is legal.
   // 64-bit arithmetic is used so that WIDTH=32 does not overflow.
   function automatic bit params_ok(input int width,
                                    input longint unsigned max_val,
                                    input int presc);
      longint unsigned lim;
      lim = (64'd1 << width) - 64'd1;
      return (width >= 2) && (width <= 32) &&
             (max_val >= 64'd1) && (max_val <= lim) &&
             (presc >= 1) && (presc <= 65535);
   endfunction

endpackage

// File: rtl/contatore_presc.sv
// rtl/contatore_presc.sv - enable-gated prescaler producing a one-cycle count tick
//
// Purpose : counts enabled cycles and raises tick on the enabled cycle that
//           completes each group of PRESC cycles.
// Ports   : clk     - clock, rising edge
//           reset_n - synchronous active-low reset
//           enable  - advances the count when high, holds it when low
//           clear   - synchronous return of the count to 0
//           tick    - high on the enabled cycle where count == PRESC-1

module contatore_presc
   import contatore_modulo_pkg::*;
#(
   parameter int PRESC = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam logic [PRESC_CW-1:0] C_LAST = PRESC_CW'(PRESC - 1);

   logic [PRESC_CW-1:0] r_cnt;
   logic                w_at_last;

   assign w_at_last = (r_cnt == C_LAST);
   assign tick      = enable && w_at_last;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (w_at_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + PRESC_CW'(1);
         end
      end
   end

endmodule

// File: rtl/contatore_modulo.sv
// rtl/contatore_modulo.sv - up/down modulo counter with prescaler, wrap/saturate and sticky flags
//
// Purpose : registered modulo-(MAX_VAL+1) counter stepping by 'step' on each
//           prescaler tick, with terminal-count pulse and sticky crossing flags.
// Ports   : clk, reset_n (sync, active-low)
//           enable, up_down, step[WIDTH], load, load_val[WIDTH], clr_flags
//           data_out[WIDTH], tc, ovf, unf (all registered)

module contatore_modulo
   import contatore_modulo_pkg::*;
#(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter int              PRESC    = 1,
   parameter int              SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up_down,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] data_out,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   generate
      if (!params_ok(WIDTH, MAX_VAL, PRESC)) begin : g_bad_params
         $error("contatore_modulo: illegal WIDTH/MAX_VAL/PRESC combination");
      end
   endgenerate

   // All arithmetic is carried out one bit wider than the count so that
   // data_out+s and the modulus MAX_VAL+1 never truncate.
   localparam logic [WIDTH:0] C_MAXV = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] C_MODV = C_MAXV + 1'b1;

   logic [WIDTH-1:0] r_data;
   logic             r_tc;
   logic             r_ovf;
   logic             r_unf;

   logic             w_presc_tick;
   logic             w_tick;
   logic [WIDTH:0]   w_cur;
   logic [WIDTH:0]   w_step_ext;
   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_wrap_up;
   logic [WIDTH:0]   w_wrap_dn;
   logic [WIDTH:0]   w_ldv_ext;
   logic [WIDTH-1:0] w_ldv;
   logic [WIDTH-1:0] w_nxt_data;
   logic             w_up_evt;
   logic             w_dn_evt;
   logic             w_up_set;
   logic             w_dn_set;

   // Load restarts the prescale interval.
   contatore_presc #(
      .PRESC (PRESC)
   ) u_presc (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .clear   (load),
      .tick    (w_presc_tick)
   );

   // Load wins over a tick arriving on the same edge.
   assign w_tick = w_presc_tick && !load;

   assign w_cur      = {1'b0, r_data};
   assign w_step_ext = {1'b0, step};
   assign w_s        = (w_step_ext > C_MAXV) ? C_MAXV : w_step_ext;
   assign w_sum      = w_cur + w_s;
   assign w_wrap_up  = w_sum - C_MODV;
   assign w_wrap_dn  = w_cur + C_MODV - w_s;
   assign w_ldv_ext  = {1'b0, load_val};
   assign w_ldv      = (w_ldv_ext > C_MAXV) ? C_MAXV[WIDTH-1:0] : load_val;

   always_comb begin
      w_nxt_data = r_data;
      w_up_evt   = 1'b0;
      w_dn_evt   = 1'b0;
      if (up_down) begin
         if (w_sum > C_MAXV) begin
            w_up_evt   = 1'b1;
            w_nxt_data = (SATURATE == MODE_SAT) ? C_MAXV[WIDTH-1:0]
                                                : w_wrap_up[WIDTH-1:0];
         end else begin
            w_nxt_data = w_sum[WIDTH-1:0];
         end
      end else begin
         if (w_s > w_cur) begin
            w_dn_evt   = 1'b1;
            w_nxt_data = (SATURATE == MODE_SAT) ? '0 : w_wrap_dn[WIDTH-1:0];
         end else begin
            w_nxt_data = r_data - w_s[WIDTH-1:0];
         end
      end
   end

   assign w_up_set = w_tick && w_up_evt;
   assign w_dn_set = w_tick && w_dn_evt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_data <= '0;
         r_tc   <= 1'b0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else begin
         if (load) begin
            r_data <= w_ldv;
            r_tc   <= 1'b0;
         end else if (w_tick) begin
            r_data <= w_nxt_data;
            r_tc   <= w_up_evt || w_dn_evt;
         end else begin
            r_tc   <= 1'b0;
         end

         // A clear coinciding with an event keeps that event's flag.
         if (clr_flags) begin
            r_ovf <= w_up_set;
            r_unf <= w_dn_set;
         end else begin
            r_ovf <= r_ovf || w_up_set;
            r_unf <= r_unf || w_dn_set;
         end
      end
   end

   assign data_out = r_data;
   assign tc       = r_tc;
   assign ovf      = r_ovf;
   assign unf      = r_unf;

endmodule

// File: tb/tb_contatore_modulo.sv
// tb/tb_contatore_modulo.sv - self-checking bench for contatore_modulo

module tb_contatore_modulo;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       up_down;
   logic [3:0] step;
   logic       load;
   logic [3:0] load_val;
   logic       clr_flags;

   logic [3:0] a_data, s_data, p_data;
   logic       a_tc, a_ovf, a_unf;
   logic       s_tc, s_ovf, s_unf;
   logic       p_tc, p_ovf, p_unf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   contatore_modulo #(.WIDTH(4), .MAX_VAL(9), .PRESC(1), .SATURATE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
      .step(step), .load(load), .load_val(load_val), .clr_flags(clr_flags),
      .data_out(a_data), .tc(a_tc), .ovf(a_ovf), .unf(a_unf));

   contatore_modulo #(.WIDTH(4), .MAX_VAL(9), .PRESC(1), .SATURATE(1)) dut_s (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
      .step(step), .load(load), .load_val(load_val), .clr_flags(clr_flags),
      .data_out(s_data), .tc(s_tc), .ovf(s_ovf), .unf(s_unf));

   contatore_modulo #(.WIDTH(4), .MAX_VAL(9), .PRESC(3), .SATURATE(0)) dut_p (
      .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down),
      .step(step), .load(load), .load_val(load_val), .clr_flags(clr_flags),
      .data_out(p_data), .tc(p_tc), .ovf(p_ovf), .unf(p_unf));

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       ud;
      logic [3:0] stp;
      logic       ld;
      logic [3:0] ldv;
      logic       clr;
      logic [3:0] e_data;
      logic       e_tc;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=%0d expected=%0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic en, input logic ud,
                        input logic [3:0] st, input logic ld, input logic [3:0] lv,
                        input logic cl);
      reset_n   = r;
      enable    = en;
      up_down   = ud;
      step      = st;
      load      = ld;
      load_val  = lv;
      clr_flags = cl;
   endtask

   // Advance one edge and land 1 time unit after it, away from the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic en, input logic ud, input logic [3:0] st,
                      input logic ld, input logic [3:0] lv, input logic cl,
                      input logic [3:0] ed, input logic et, input logic eo, input logic eu);
      vec_t v;
      v.rst_n = r;  v.en = en;  v.ud = ud;  v.stp = st;
      v.ld = ld;    v.ldv = lv; v.clr = cl;
      v.e_data = ed; v.e_tc = et; v.e_ovf = eo; v.e_unf = eu;
      vecs.push_back(v);
   endtask

   initial begin
      // rst en ud stp ld ldv clr | data tc ovf unf   (wrap, MAX_VAL=9, PRESC=1)
      add(0, 0, 0,  0, 0,  0, 0,   0, 0, 0, 0);  // reset state
      add(1, 0, 0,  0, 1,  8, 0,   8, 0, 0, 0);  // load 8
      add(1, 1, 1,  1, 0,  0, 0,   9, 0, 0, 0);  // up to MAX, no event
      add(1, 1, 1,  1, 0,  0, 0,   0, 1, 1, 0);  // wrap to 0, tc, ovf
      add(1, 0, 1,  1, 0,  0, 0,   0, 0, 1, 0);  // tc lasts one cycle
      add(1, 0, 0,  0, 1,  1, 0,   1, 0, 1, 0);  // load 1
      add(1, 1, 0,  3, 0,  0, 0,   8, 1, 1, 1);  // 1-3 wraps to 8, unf
      add(1, 0, 0,  0, 0,  0, 1,   8, 0, 0, 0);  // clr on quiet edge
      add(1, 0, 0,  0, 1, 12, 0,   9, 0, 0, 0);  // load clamps to MAX_VAL
      add(1, 1, 1,  0, 0,  0, 0,   9, 0, 0, 0);  // step 0 holds
      add(1, 1, 1, 15, 0,  0, 0,   8, 1, 1, 0);  // step clamped to 9: 18-10
      add(1, 1, 1,  2, 0,  0, 1,   0, 1, 1, 0);  // clr with up event keeps ovf
      add(1, 1, 0,  5, 0,  0, 0,   5, 1, 1, 1);  // 0-5 wraps to 5
      add(1, 1, 1,  4, 1,  3, 0,   3, 0, 1, 1);  // load beats tick
      add(0, 1, 1,  1, 1,  5, 1,   0, 0, 0, 0);  // reset beats load
      add(1, 1, 0,  1, 0,  0, 0,   9, 1, 0, 1);  // 0-1 wraps to 9
      add(1, 1, 1,  1, 0,  0, 1,   0, 1, 1, 0);  // up event, clr drops unf

      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].en, vecs[i].ud, vecs[i].stp,
               vecs[i].ld, vecs[i].ldv, vecs[i].clr);
         cycle();
         chk("vec_data", i, 32'(a_data), 32'(vecs[i].e_data));
         chk("vec_tc",   i, 32'(a_tc),   32'(vecs[i].e_tc));
         chk("vec_ovf",  i, 32'(a_ovf),  32'(vecs[i].e_ovf));
         chk("vec_unf",  i, 32'(a_unf),  32'(vecs[i].e_unf));
      end

      // Saturate build: clamped at MAX_VAL, event repeats every tick.
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      drive(1, 0, 1, 3, 1, 8, 0);
      cycle();
      chk("sat_load", 0, 32'(s_data), 32'd8);
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 1, 3, 0, 0, 0);
         cycle();
         chk("sat_up_data", k, 32'(s_data), 32'd9);
         chk("sat_up_tc",   k, 32'(s_tc),   32'd1);
         chk("sat_up_ovf",  k, 32'(s_ovf),  32'd1);
      end
      drive(1, 0, 0, 3, 1, 1, 0);
      cycle();
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, 0, 3, 0, 0, 0);
         cycle();
         chk("sat_dn_data", k, 32'(s_data), 32'd0);
         chk("sat_dn_tc",   k, 32'(s_tc),   32'd1);
         chk("sat_dn_unf",  k, 32'(s_unf),  32'd1);
      end
      chk("sat_ovf_kept", 0, 32'(s_ovf), 32'd1);

      // Prescaler build: one increment per 3 enabled cycles.
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("presc_reset", 0, 32'(p_data), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         drive(1, 1, 1, 1, 0, 0, 0);
         cycle();
         chk("presc_run", k, 32'(p_data), 32'(k / 3));
      end
      begin
         logic       en_seq[5];
         logic [3:0] exp_seq[5];
         en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         exp_seq = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
         for (int k = 0; k < 5; k++) begin
            drive(1, en_seq[k], 1, 1, 0, 0, 0);
            cycle();
            chk("presc_gap", k, 32'(p_data), 32'(exp_seq[k]));
            chk("presc_gap_tc", k, 32'(p_tc), 32'd0);
         end
      end
      // Reset mid-prescale must restart the interval.
      drive(1, 1, 1, 1, 0, 0, 0);
      cycle();
      drive(0, 1, 1, 1, 0, 0, 0);
      cycle();
      chk("presc_midrst", 0, 32'(p_data), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         drive(1, 1, 1, 1, 0, 0, 0);
         cycle();
         chk("presc_after_rst", k, 32'(p_data), 32'(k / 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/contatore_modulo.md
CONTATORE_MODULO -- requirements
Module: contatore_modulo

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value, range 1..2**WIDTH-1; modulus = MAX_VAL+1.
REQ-003 Parameter PRESC, default 1: enabled cycles per count tick, range 1..65535.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at bounds, 1 = clamp at bounds.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  advances prescaler when high; holds all state when low.
REQ-008 up_down  input  1  1 = count up, 0 = count down; sampled on tick cycles.
REQ-009 step  input  WIDTH  increment magnitude per tick; 0 = hold.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value written on load.
REQ-012 clr_flags  input  1  clears sticky flags.
REQ-013 data_out  output  WIDTH  registered count.
REQ-014 tc  output  1  registered terminal-count pulse.
REQ-015 ovf  output  1  sticky up-crossing flag.
REQ-016 unf  output  1  sticky down-crossing flag.

Function
REQ-017 Priority per edge: reset_n low > load > tick; exactly one applies.
REQ-018 Load: data_out <= min(load_val, MAX_VAL); prescaler count <= 0; tc <= 0; flags unchanged.
REQ-019 Tick = enable high and prescaler count == PRESC-1; prescaler then returns to 0, else increments on enabled cycles; PRESC=1 makes tick == enable.
REQ-020 Effective step s = min(step, MAX_VAL); arithmetic in WIDTH+1 bits, no intermediate truncation.
REQ-021 Up tick, data_out+s <= MAX_VAL: data_out <= data_out+s, no event.
REQ-022 Up tick, data_out+s > MAX_VAL: up event; wrap mode data_out <= data_out+s-(MAX_VAL+1); saturate mode data_out <= MAX_VAL.
REQ-023 Down tick, s <= data_out: data_out <= data_out-s, no event.
REQ-024 Down tick, s > data_out: down event; wrap mode data_out <= data_out-s+(MAX_VAL+1); saturate mode data_out <= 0.
REQ-025 Event repeats on every tick that crosses a bound, including while already clamped in saturate mode.
REQ-026 tc high for exactly the cycle following an event edge (coincident with the new data_out); low otherwise.
REQ-027 ovf set on up event, unf set on down event; both held until clr_flags.
REQ-028 clr_flags same edge as an event: the event's flag ends set, the other flag clears.
REQ-029 Latency: data_out reflects tick/load one clock after the sampling edge; no combinational input-to-output path.
REQ-030 step=0 on a tick: data_out unchanged, no event, prescaler still advances.

Reset
REQ-031 reset_n low at a rising edge: data_out=0, tc=0, ovf=0, unf=0, prescaler count=0.
REQ-032 Reset overrides load, tick and clr_flags issued the same edge, including mid-prescale.
REQ-033 No asynchronous reset path; reset_n is not in any sensitivity other than clk.

Structure
REQ-034 Shared package holds mode constants (MODE_WRAP=0, MODE_SAT=1) and the parameter-range check function.
REQ-035 Prescaler is one sub-module, contatore_presc (inputs clk, reset_n, enable, clear; output tick), parameter PRESC.
REQ-036 Elaboration error when MAX_VAL > 2**WIDTH-1 or PRESC < 1.

Verification
REQ-037 WIDTH=4, MAX_VAL=9, wrap: load 8, step=1, up, 2 ticks -> data_out 9 then 0; tc high 1 cycle with 0; ovf=1.
REQ-038 Same build: load 1, step=3, down, 1 tick -> data_out 8, tc pulse, unf=1, ovf unchanged.
REQ-039 SATURATE=1, MAX_VAL=9: load 8, step=3, up, 3 ticks -> data_out 9,9,9; tc high after each tick; ovf=1.
REQ-040 PRESC=3: enable high 9 cycles, step=1, up from 0 -> data_out increments after cycles 3, 6, 9, ending at 3; enable low 2 cycles mid-run delays increments by 2.
REQ-041 load_val=12 with MAX_VAL=9 -> data_out 9; reset_n low same edge as load -> data_out 0, all flags 0.
REQ-042 ovf=1, clr_flags asserted on an up-event edge -> ovf stays 1; clr_flags on quiet edge -> ovf and unf both 0.
